pc_sequencer: RTL

Control block that drives the select and target inputs of the core's program-counter register every cycle. It arbitrates between sequential fetch, taken branches, register jumps, restart, stall and halt. It also generates the pipeline flush pulse-train after any redirect. It sits between the execute-stage resolution logic, the instruction-memory handshake and the PC register.

---
 rtl/core_pkg.sv | 29 ++
 rtl/pc_sequencer_redirect_arb.sv | 30 +++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core front-end control blocks.
package core_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_ZERO   = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH,
        HALTED
    } pcseq_state_e;

    localparam int FLUSH_CNT_W = 3;

    // Bit positions inside the one-hot redirect winner vector.
    localparam int WIN_JUMP    = 0;
    localparam int WIN_BRANCH  = 1;
    localparam int WIN_RESTART = 2;

    function automatic logic is_redirect(input logic [2:0] winner);
        return |winner;
    endfunction

endpackage

// File: rtl/pc_sequencer_redirect_arb.sv
// Fixed-priority pick between restart, taken branch and register jump.
// Branch and jump requests are masked while the gate is active because they come from squashed work.
module redirect_arb
    import core_pkg::*;
(
    input  logic        restart_req,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        flush_active,
    output logic [2:0]  winner,
    output logic [31:0] target
);

    always_comb begin
        winner = '0;
        target = '0;
        if (restart_req) begin
            winner[WIN_RESTART] = 1'b1;
        end else if (br_valid && !flush_active) begin
            winner[WIN_BRANCH] = 1'b1;
            target             = br_target;
        end else if (jr_valid && !flush_active) begin
            winner[WIN_JUMP] = 1'b1;
            target           = jr_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Drives the PC register select/targets each cycle and produces the flush pulse-train after redirects.
// Holding the PC is done by selecting the branch input with pc_in fed back as the target.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int INIT_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        restart_req,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [1:0]  pc_choice,
    output logic [31:0] pc_branch_target,
    output logic [31:0] pc_jump_target,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] INIT_LAST  = FLUSH_CNT_W'(INIT_CYCLES - 1);

    pcseq_state_e            state;
    logic [FLUSH_CNT_W-1:0]  init_cnt;
    logic [FLUSH_CNT_W-1:0]  flush_cnt;
    logic [2:0]              winner;
    logic [31:0]             redir_target;
    logic                    redirect;
    logic                    hold;

    redirect_arb u_arb (
        .restart_req  (restart_req),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .jr_valid     (jr_valid),
        .jr_target    (jr_target),
        .flush_active (state != RUN),
        .winner       (winner),
        .target       (redir_target)
    );

    assign redirect = is_redirect(winner);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt >= INIT_LAST) begin
                        state <= RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (halt_req) begin
                        state <= HALTED;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (halt_req) begin
                        state     <= HALTED;
                        flush_cnt <= '0;
                    end else if (flush_cnt <= 1) begin
                        state     <= RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (restart_req) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (!halt_req) begin
                        state <= RUN;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // PC steering is combinational so the PC register follows in the same edge.
    always_comb begin
        pc_choice        = PC_SEQ;
        pc_branch_target = br_target;
        pc_jump_target   = jr_target;
        fetch_valid      = 1'b0;
        hold             = 1'b0;
        if (reset) begin
            pc_choice        = PC_ZERO;
            pc_branch_target = pc_in;
            pc_jump_target   = pc_in;
        end else begin
            case (state)
                INIT: pc_choice = PC_ZERO;
                RUN, FLUSH: begin
                    if (winner[WIN_RESTART]) begin
                        pc_choice = PC_ZERO;
                    end else if (winner[WIN_BRANCH]) begin
                        pc_choice        = PC_BRANCH;
                        pc_branch_target = redir_target;
                    end else if (winner[WIN_JUMP]) begin
                        pc_choice      = PC_JUMP;
                        pc_jump_target = redir_target;
                    end else if (halt_req || stall || !imem_ready) begin
                        hold = 1'b1;
                    end else begin
                        pc_choice   = PC_SEQ;
                        fetch_valid = 1'b1;
                    end
                end
                HALTED: begin
                    if (restart_req) begin
                        pc_choice = PC_ZERO;
                    end else begin
                        hold = 1'b1;
                    end
                end
                default: pc_choice = PC_ZERO;
            endcase
            if (hold) begin
                pc_choice        = PC_BRANCH;
                pc_branch_target = pc_in;
                pc_jump_target   = pc_in;
            end
        end
    end

    always_comb begin
        flush  = (state == FLUSH) && !reset;
        halted = (state == HALTED) && !reset;
    end

endmodule
